bcd_rtc_scan: RTL
=================

Name: bcd_rtc_scan

Overview:
Parametrised BCD real-time clock with an integrated multiplexed 7-segment display scanner. It counts HH:MM:SS in BCD from an external 1 Hz enable and supports a validated synchronous time load. It presents 24 h or 12 h display with a PM flag and scans 4 (HH:MM) or 6 (HH:MM:SS) common-anode digits. It feeds the alarm comparator through the BCD time outputs and minute/day pulses.

Parameters:
NUM_DIGITS, 4, number of scanned digits; legal values 4 (HH:MM) or 6 (HH:MM:SS)
SCAN_DIV, 50000, clk cycles each digit stays enabled; legal range >= 2
BLANK_LZ, 1, 1 = blank the hour-tens digit on the display when it is 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick_1hz  in  1  one-cycle enable, one pulse per second
mode12  in  1  0 = 24 h display, 1 = 12 h display; affects display and disp_hh only
load  in  1  one-cycle request to load ld_hh/ld_mm/ld_ss
ld_hh  in  8  BCD hours, 24 h format {tens,ones}
ld_mm  in  8  BCD minutes
ld_ss  in  8  BCD seconds
hh  out  8  BCD hours, always 24 h
mm  out  8  BCD minutes
ss  out  8  BCD seconds
disp_hh  out  8  BCD hours as displayed (12 h converted when mode12=1)
pm  out  1  1 when hh >= 12
min_pulse  out  1  one-cycle pulse when ss wraps 59->00
day_pulse  out  1  one-cycle pulse when time wraps 23:59:59->00:00:00
load_err  out  1  one-cycle pulse when a load is rejected
seg  out  7  {g,f,e,d,c,b,a}, active-low
an  out  NUM_DIGITS  digit enables, active-low, one-hot

Behaviour:
- Clocking and reset:
  - Single clock domain. All state changes on the clk rising edge.
  - rst is synchronous, active-high, and takes effect at the next edge, including mid-load or mid-scan.
  - Reset values: hh=mm=ss=8'h00; pm=0; min_pulse=day_pulse=load_err=0; scan index=0; scan counter=0; an = all ones (all off); seg=7'h7F.
  - First digit enable appears on the first edge after rst deasserts.
- Time counting:
  - On a cycle with tick_1hz=1, the time advances by one second and is visible the next cycle.
  - BCD carry chain:
    - ss ones 9->0 increments ss tens; ss tens 5->0 increments minutes.
    - Minutes follow the same pattern.
    - Hours: ones 9->0 increments tens; 23->00.
  - No binary intermediate state is ever visible; every nibble is always 0-9.
- Pulses:
  - min_pulse: high for exactly the cycle after a tick that produces ss=00.
  - day_pulse: high for exactly the cycle after a tick that produces 00:00:00; min_pulse is also high in that cycle.
- Load:
  - When load=1, the fields are checked: every nibble <=9, hh<=8'h23, mm<=8'h59, ss<=8'h59.
  - Valid: hh/mm/ss take the loaded values next cycle.
  - Invalid: time is unchanged and load_err pulses high for one cycle.
  - load with tick_1hz in the same cycle: load wins, the tick is discarded, and no min/day pulse is produced.
- 12 h conversion (combinational from hh):
  - hh 00 -> 12; 01..12 -> unchanged; 13..23 -> hh-12 in BCD.
  - mode12=0 -> disp_hh=hh.
  - pm = (hh >= 8'h12) regardless of mode.
- Scan:
  - Free-running counter 0..SCAN_DIV-1. On wrap, digit index advances 0..NUM_DIGITS-1 and back to 0. Every digit is visited in order with none skipped.
  - Index to digit mapping:
    - NUM_DIGITS=6: 0=ss ones, 1=ss tens, 2=mm ones, 3=mm tens, 4=disp_hh ones, 5=disp_hh tens.
    - NUM_DIGITS=4: 0=mm ones, 1=mm tens, 2=disp_hh ones, 3=disp_hh tens.
  - an and seg are both registered and updated on the same edge, so the enabled digit always shows its own value.
  - an[index]=0, all other bits 1.
- Segment decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other value -> 1111111.
  - BLANK_LZ=1 and hour-tens digit displayed = 0 -> seg=1111111 while an still cycles normally.
- Time updates reach seg no later than the next digit slot.

Test Plan:
- Reset, NUM_DIGITS=4, SCAN_DIV=4: hold rst 3 cycles, release -> hh/mm/ss=00, an walks 1110,1101,1011,0111,1110 every 4 cycles, seg=1000000 on digits 0-2, seg=1111111 on digit 3 (BLANK_LZ).
- Load 23:59:58, then pulse tick_1hz twice -> 23:59:59, then 00:00:00; min_pulse and day_pulse each high exactly one cycle after the second tick.
- Load ld_hh=8'h24, then ld_mm=8'h5A -> each load gives load_err one-cycle pulse and time unchanged.
- load=1 and tick_1hz=1 in the same cycle with 10:00:59 -> time=10:00:59, min_pulse stays 0.
- mode12=1, load 00:30:00, 12:00:00, 13:45:00 -> disp_hh=12/pm=0, 12/pm=1, 01/pm=1.
- NUM_DIGITS=6, time 09:08:07, assert rst mid-scan at index 4 -> next cycle an=all ones, time 00:00:00, scan restarts at index 0.

Source files
------------

// File: rtl/bcd_rtc_scan.sv
// BCD HH:MM:SS real-time clock with validated load, 12/24 h display conversion
// and a multiplexed common-anode 7-segment scanner.
module bcd_rtc_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic                  mode12,
    input  logic                  load,
    input  logic [7:0]            ld_hh,
    input  logic [7:0]            ld_mm,
    input  logic [7:0]            ld_ss,
    output logic [7:0]            hh,
    output logic [7:0]            mm,
    output logic [7:0]            ss,
    output logic [7:0]            disp_hh,
    output logic                  pm,
    output logic                  min_pulse,
    output logic                  day_pulse,
    output logic                  load_err,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // In 4-digit mode the seconds digits are skipped, so index 0 maps to mm ones.
    localparam logic [2:0] SEL_OFS = (NUM_DIGITS == 4) ? 3'd2 : 3'd0;

    logic [7:0]            hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic                  min_pulse_q, min_pulse_d, day_pulse_q, day_pulse_d;
    logic                  load_err_q, load_err_d;
    logic [CW-1:0]         scan_cnt_q, scan_cnt_d;
    logic [2:0]            scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic                  ld_ok, cnt_wrap;
    logic [4:0]            hb, h12;
    logic [7:0]            disp12;
    logic [2:0]            sel;
    logic [3:0]            digit;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            inc60 = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        else
            inc60 = {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        if (v == 8'h23)
            inc_hour = 8'h00;
        else if (v[3:0] == 4'd9)
            inc_hour = {v[7:4] + 4'd1, 4'd0};
        else
            inc_hour = {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        ld_ok = (ld_hh[3:0] <= 4'd9) && (ld_hh[7:4] <= 4'd9) && (ld_hh <= 8'h23) &&
                (ld_mm[3:0] <= 4'd9) && (ld_mm[7:4] <= 4'd9) && (ld_mm <= 8'h59) &&
                (ld_ss[3:0] <= 4'd9) && (ld_ss[7:4] <= 4'd9) && (ld_ss <= 8'h59);
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        min_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        load_err_d  = 1'b0;
        // A load always takes the cycle; a coincident tick is dropped.
        if (load) begin
            if (ld_ok) begin
                hh_d = ld_hh;
                mm_d = ld_mm;
                ss_d = ld_ss;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick_1hz) begin
            ss_d = inc60(ss_q);
            if (ss_q == 8'h59) begin
                min_pulse_d = 1'b1;
                mm_d        = inc60(mm_q);
                if (mm_q == 8'h59) begin
                    hh_d        = inc_hour(hh_q);
                    day_pulse_d = (hh_q == 8'h23);
                end
            end
        end
    end

    always_comb begin
        hb     = {1'b0, hh_q[7:4]} * 5'd10 + {1'b0, hh_q[3:0]};
        h12    = (hb == 5'd0) ? 5'd12 : ((hb > 5'd12) ? hb - 5'd12 : hb);
        disp12 = (h12 >= 5'd10) ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, h12[3:0]};
    end

    assign disp_hh = mode12 ? disp12 : hh_q;
    assign pm      = (hh_q >= 8'h12);

    always_comb begin
        cnt_wrap   = (scan_cnt_q == CW'(SCAN_DIV - 1));
        scan_cnt_d = cnt_wrap ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (cnt_wrap)
            scan_idx_d = (scan_idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx_q + 3'd1;
        an_d = ~(NUM_DIGITS'(1) << scan_idx_q);
        sel  = scan_idx_q + SEL_OFS;
        case (sel)
            3'd0:    digit = ss_q[3:0];
            3'd1:    digit = ss_q[7:4];
            3'd2:    digit = mm_q[3:0];
            3'd3:    digit = mm_q[7:4];
            3'd4:    digit = disp_hh[3:0];
            default: digit = disp_hh[7:4];
        endcase
        seg_d = (BLANK_LZ && (sel == 3'd5) && (digit == 4'd0)) ? 7'h7F : seg_decode(digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            min_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
            scan_cnt_q  <= '0;
            scan_idx_q  <= 3'd0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
        end else begin
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            min_pulse_q <= min_pulse_d;
            day_pulse_q <= day_pulse_d;
            load_err_q  <= load_err_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign hh        = hh_q;
    assign mm        = mm_q;
    assign ss        = ss_q;
    assign min_pulse = min_pulse_q;
    assign day_pulse = day_pulse_q;
    assign load_err  = load_err_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule
